pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, sets the busy cycles after a mult/multu issues from E; legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 10, sets the busy cycles after a div/divu issues from E; legal range 1..15.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instr_D  in  32  instruction word in the D stage.
REQ-006 stall  out  1  hold PC and the D register this cycle.
REQ-007 nPC_sel_D  out  2  0 = PC+4, 1 = beq, 2 = j/jal, 3 = jr; combinational from instr_D.
REQ-008 ExtOp_D  out  2  0 = zero-extend, 1 = sign-extend, 2 = load-upper; combinational from instr_D.
REQ-009 ALUSrc_E  out  1  select the immediate operand.
REQ-010 ALUctr_E  out  3  0 = add, 1 = sub, 2 = or, 3 = compare.
REQ-011 md_start_E  out  1  mult/div unit start strobe.
REQ-012 md_op_E  out  3  0 = mult, 1 = multu, 2 = div, 3 = divu, 4 = mthi, 5 = mtlo.
REQ-013 MemWrite_M  out  1  data-memory write enable.
REQ-014 A3_E, A3_M, A3_W  out  5 each  destination register per stage; 0 = no write.
REQ-015 RegWrite_W  out  1  register-file write enable.
REQ-016 MemtoReg_W  out  2  0 = ALU, 1 = memory, 2 = PC+8, 3 = HI/LO.
REQ-017 busy  out  1  mult/div unit still computing.

Function
REQ-018 Decoded set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo; any other encoding decodes as a nop with all enables 0.
REQ-019 Destination: rd for addu/subu/mfhi/mflo; rt for ori/lw/lui; 31 for jal; 0 otherwise.
REQ-020 Register use: rs is read by all except lui/j/jal/mfhi/mflo; rt is read by addu/subu/sw/beq/mult/multu/div/divu.
REQ-021 The decoded D bundle is registered into E, E into M, and M into W on every clock; each output comes from its stage register.
REQ-022 Stall condition A (load-use): E holds lw, A3_E != 0, and A3_E equals a register D reads.
REQ-023 Stall condition B (branch operand): D holds beq/jr, and either E writes a nonzero A3_E that D reads, or M holds lw with a nonzero A3_M that D reads.
REQ-024 Stall condition C (mult/div): D holds a mult/div/mfhi/mflo/mthi/mtlo instruction, and either busy = 1 or md_start_E = 1.
REQ-025 stall = A | B | C, combinational.
REQ-026 While stall = 1, the E register loads an all-zero bubble, and M and W advance normally.
REQ-027 md_start_E = 1 for exactly one cycle, while mult/multu/div/divu occupies E.
REQ-028 Counter cnt (4 bits), loaded at the edge ending a start cycle: MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
REQ-029 Otherwise cnt decrements by 1 per cycle, saturating at 0.
REQ-030 busy = (cnt != 0).
REQ-031 mthi/mtlo assert md_op_E but do not load cnt.
REQ-032 Simultaneous start and nonzero cnt cannot occur (guaranteed by REQ-024); if forced, the load wins.
REQ-033 A3 = 0 never causes a stall and never asserts RegWrite_W.

Reset
REQ-034 Synchronous reset clears E, M, W and cnt to 0; all registered outputs are 0 the cycle after reset.
REQ-035 Reset takes priority over stall.
REQ-036 Reset during busy clears cnt immediately, so busy = 0 in the next cycle.

Verification
REQ-037 lw $8,0($0) followed by addu $9,$8,$8 -> stall = 1 for exactly one cycle, then one bubble in E (A3_E = 0), then addu proceeds with A3_W = 9.
REQ-038 ori $5,$0,1 followed by beq $5,$5 -> stall = 1 for one cycle; with a nop between them -> no stall.
REQ-039 mult $1,$2 then mflo $3, default parameters -> md_start_E pulses once; busy = 1 for 5 cycles; mflo is stalled until busy = 0, then MemtoReg_W = 3 and A3_W = 3.
REQ-040 div with DIV_CYCLES = 3, and reset asserted on the second busy cycle -> busy = 0 and all stage outputs = 0 the following cycle.
REQ-041 jal at D -> nPC_sel_D = 2, and three cycles later A3_W = 31, MemtoReg_W = 2, RegWrite_W = 1.
REQ-042 addu $0,$1,$2 followed by addu $4,$0,$0 -> no stall, and RegWrite_W = 0 for the first instruction.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- control unit for a five-stage MIPS-subset pipeline.
//
// Decodes the D-stage instruction, carries the decoded control bundle through
// the E, M and W stage registers, detects hazards that require the front end
// to hold, and tracks how long the multiply/divide unit stays busy.
//
// Parameters
//   MULT_CYCLES  busy cycles after a mult/multu leaves E (1..15)
//   DIV_CYCLES   busy cycles after a div/divu leaves E   (1..15)
//
// Ports
//   clk         in   clock, all state on the rising edge
//   reset       in   synchronous active-high reset
//   instr_D     in   instruction word in D
//   stall       out  hold PC and the D register this cycle
//   nPC_sel_D   out  0 PC+4, 1 beq, 2 j/jal, 3 jr (combinational)
//   ExtOp_D     out  0 zero-ext, 1 sign-ext, 2 load-upper (combinational)
//   ALUSrc_E    out  immediate operand select
//   ALUctr_E    out  0 add, 1 sub, 2 or, 3 compare
//   md_start_E  out  mult/div start strobe
//   md_op_E     out  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//   MemWrite_M  out  data-memory write enable
//   A3_E/M/W    out  destination register per stage, 0 = no write
//   RegWrite_W  out  register-file write enable
//   MemtoReg_W  out  0 ALU, 1 memory, 2 PC+8, 3 HI/LO
//   busy        out  mult/div unit still computing
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  output logic        stall,
  output logic [1:0]  nPC_sel_D,
  output logic [1:0]  ExtOp_D,
  output logic        ALUSrc_E,
  output logic [2:0]  ALUctr_E,
  output logic        md_start_E,
  output logic [2:0]  md_op_E,
  output logic        MemWrite_M,
  output logic [4:0]  A3_E,
  output logic [4:0]  A3_M,
  output logic [4:0]  A3_W,
  output logic        RegWrite_W,
  output logic [1:0]  MemtoReg_W,
  output logic        busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef struct packed {
    logic       alusrc;
    logic [2:0] aluctr;
    logic       md_start;
    logic [2:0] md_op;
    logic       memwrite;
    logic [4:0] a3;
    logic       regwrite;
    logic [1:0] memtoreg;
    logic       is_lw;
  } ctrl_t;

  // ---------------------------------------------------------------------------
  // D stage: decode
  // ---------------------------------------------------------------------------
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;

  assign op    = instr_D[31:26];
  assign rs    = instr_D[25:21];
  assign rt    = instr_D[20:16];
  assign rd    = instr_D[15:11];
  assign shamt = instr_D[10:6];
  assign funct = instr_D[5:0];

  ctrl_t      dec;
  logic       rs_use, rt_use, is_br, is_md;
  logic [1:0] npc_sel, ext_op;

  always_comb begin
    dec     = '0;
    rs_use  = 1'b0;
    rt_use  = 1'b0;
    is_br   = 1'b0;
    is_md   = 1'b0;
    npc_sel = 2'd0;
    ext_op  = 2'd0;
    unique case (op)
      // R-type encodings with a nonzero shamt field are not part of the set
      6'h00: if (shamt == 5'd0) begin
        unique case (funct)
          6'h21: begin dec.a3 = rd; rs_use = 1'b1; rt_use = 1'b1; end
          6'h23: begin dec.a3 = rd; dec.aluctr = 3'd1; rs_use = 1'b1; rt_use = 1'b1; end
          6'h08: begin npc_sel = 2'd3; rs_use = 1'b1; is_br = 1'b1; end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            // funct[1:0] already enumerates mult, multu, div, divu as 0..3
            dec.md_start = 1'b1;
            dec.md_op    = {1'b0, funct[1:0]};
            rs_use = 1'b1; rt_use = 1'b1; is_md = 1'b1;
          end
          6'h10, 6'h12: begin dec.a3 = rd; dec.memtoreg = 2'd3; is_md = 1'b1; end
          6'h11: begin dec.md_op = 3'd4; rs_use = 1'b1; is_md = 1'b1; end
          6'h13: begin dec.md_op = 3'd5; rs_use = 1'b1; is_md = 1'b1; end
          default: ;
        endcase
      end
      6'h0d: begin dec.a3 = rt; dec.alusrc = 1'b1; dec.aluctr = 3'd2; rs_use = 1'b1; end
      6'h0f: begin dec.a3 = rt; dec.alusrc = 1'b1; ext_op = 2'd2; end
      6'h23: begin
        dec.a3 = rt; dec.alusrc = 1'b1; dec.memtoreg = 2'd1; dec.is_lw = 1'b1;
        ext_op = 2'd1; rs_use = 1'b1;
      end
      6'h2b: begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; ext_op = 2'd1; rs_use = 1'b1; rt_use = 1'b1; end
      6'h04: begin
        dec.aluctr = 3'd3; npc_sel = 2'd1; ext_op = 2'd1;
        rs_use = 1'b1; rt_use = 1'b1; is_br = 1'b1;
      end
      6'h02: npc_sel = 2'd2;
      6'h03: begin npc_sel = 2'd2; dec.a3 = 5'd31; dec.memtoreg = 2'd2; end
      default: ;
    endcase
    // $0 as destination is never a real write
    dec.regwrite = (dec.a3 != 5'd0);
  end

  assign nPC_sel_D = npc_sel;
  assign ExtOp_D   = ext_op;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  ctrl_t      e_q, e_d;
  logic       m_memwrite_q, m_regwrite_q, m_is_lw_q;
  logic [4:0] m_a3_q;
  logic [1:0] m_memtoreg_q;
  logic [4:0] w_a3_q;
  logic       w_regwrite_q;
  logic [1:0] w_memtoreg_q;
  logic [3:0] cnt_q, cnt_d;

  logic hit_e, hit_m, stall_a, stall_b, stall_c;

  // A zero destination never matches, so $0 reads cannot cause a stall
  assign hit_e = (e_q.a3 != 5'd0) &&
                 ((rs_use && (rs == e_q.a3)) || (rt_use && (rt == e_q.a3)));
  assign hit_m = (m_a3_q != 5'd0) &&
                 ((rs_use && (rs == m_a3_q)) || (rt_use && (rt == m_a3_q)));

  assign stall_a = e_q.is_lw && hit_e;
  assign stall_b = is_br && (hit_e || (m_is_lw_q && hit_m));
  assign stall_c = is_md && (busy || e_q.md_start);
  assign stall   = stall_a | stall_b | stall_c;

  assign e_d = stall ? ctrl_t'('0) : dec;

  // ---------------------------------------------------------------------------
  // Mult/div busy counter: the start cycle loads, otherwise count down to 0
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (e_q.md_start) begin
      // md_op[1] separates div/divu (2,3) from mult/multu (0,1)
      cnt_d = e_q.md_op[1] ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign busy = (cnt_q != 4'd0);

  // ---------------------------------------------------------------------------
  // D -> E -> M -> W stage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= '0;
      m_memwrite_q <= 1'b0;
      m_regwrite_q <= 1'b0;
      m_is_lw_q    <= 1'b0;
      m_a3_q       <= '0;
      m_memtoreg_q <= '0;
      w_a3_q       <= '0;
      w_regwrite_q <= 1'b0;
      w_memtoreg_q <= '0;
      cnt_q        <= '0;
    end else begin
      e_q          <= e_d;
      m_memwrite_q <= e_q.memwrite;
      m_regwrite_q <= e_q.regwrite;
      m_is_lw_q    <= e_q.is_lw;
      m_a3_q       <= e_q.a3;
      m_memtoreg_q <= e_q.memtoreg;
      w_a3_q       <= m_a3_q;
      w_regwrite_q <= m_regwrite_q;
      w_memtoreg_q <= m_memtoreg_q;
      cnt_q        <= cnt_d;
    end
  end

  assign ALUSrc_E   = e_q.alusrc;
  assign ALUctr_E   = e_q.aluctr;
  assign md_start_E = e_q.md_start;
  assign md_op_E    = e_q.md_op;
  assign A3_E       = e_q.a3;
  assign MemWrite_M = m_memwrite_q;
  assign A3_M       = m_a3_q;
  assign A3_W       = w_a3_q;
  assign RegWrite_W = w_regwrite_q;
  assign MemtoReg_W = w_memtoreg_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D;
  logic        stall;
  logic [1:0]  nPC_sel_D;
  logic [1:0]  ExtOp_D;
  logic        ALUSrc_E;
  logic [2:0]  ALUctr_E;
  logic        md_start_E;
  logic [2:0]  md_op_E;
  logic        MemWrite_M;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic        RegWrite_W;
  logic [1:0]  MemtoReg_W;
  logic        busy;

  always #5 clk = ~clk;

  pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .instr_D(instr_D), .stall(stall),
    .nPC_sel_D(nPC_sel_D), .ExtOp_D(ExtOp_D), .ALUSrc_E(ALUSrc_E),
    .ALUctr_E(ALUctr_E), .md_start_E(md_start_E), .md_op_E(md_op_E),
    .MemWrite_M(MemWrite_M), .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .busy(busy)
  );

  typedef struct packed {
    logic       alusrc;
    logic [2:0] aluctr;
    logic       mds;
    logic [2:0] mdo;
    logic       mw;
    logic [4:0] a3;
    logic       rw;
    logic [1:0] mtr;
  } ent_t;

  ent_t  q[$];
  int    checks = 0;
  int    errors = 0;
  string cur = "init";

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic ent_t mk(input logic alusrc, input logic [2:0] aluctr, input logic mds,
                              input logic [2:0] mdo, input logic mw, input logic [4:0] a3,
                              input logic rw, input logic [1:0] mtr);
    return '{alusrc, aluctr, mds, mdo, mw, a3, rw, mtr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  // One D-stage cycle: check the current pipeline against the scoreboard,
  // then record what E must hold after this edge (a bubble when stalled).
  task automatic step(input logic [31:0] ins, input logic st, input logic bsy, input ent_t e);
    ent_t w_e, m_e, e_e;
    instr_D = ins;
    @(negedge clk);
    chk("stall", stall, st);
    chk("busy", busy, bsy);
    w_e = q.pop_front();
    m_e = q[0];
    e_e = q[1];
    chk("A3_W", A3_W, w_e.a3);
    chk("RegWrite_W", RegWrite_W, w_e.rw);
    chk("MemtoReg_W", MemtoReg_W, w_e.mtr);
    chk("A3_M", A3_M, m_e.a3);
    chk("MemWrite_M", MemWrite_M, m_e.mw);
    chk("A3_E", A3_E, e_e.a3);
    chk("ALUSrc_E", ALUSrc_E, e_e.alusrc);
    chk("ALUctr_E", ALUctr_E, e_e.aluctr);
    chk("md_start_E", md_start_E, e_e.mds);
    chk("md_op_E", md_op_E, e_e.mdo);
    q.push_back(st ? ent_t'('0) : e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_A3_E", A3_E, 0);
    chk("rst_A3_M", A3_M, 0);
    chk("rst_A3_W", A3_W, 0);
    chk("rst_RegWrite_W", RegWrite_W, 0);
    chk("rst_MemtoReg_W", MemtoReg_W, 0);
    chk("rst_MemWrite_M", MemWrite_M, 0);
    chk("rst_md_start_E", md_start_E, 0);
    chk("rst_md_op_E", md_op_E, 0);
    chk("rst_ALUSrc_E", ALUSrc_E, 0);
    chk("rst_ALUctr_E", ALUctr_E, 0);
    q.delete();
    repeat (3) q.push_back('0);
  endtask

  task automatic flush();
    repeat (3) step(NOP, 0, 0, '0);
  endtask

  initial begin
    ent_t lw8, addu9, ori5, beq_e, mult_e, mflo3;
    reset   = 1'b1;
    instr_D = NOP;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    lw8    = mk(1, 0, 0, 0, 0, 8, 1, 1);
    addu9  = mk(0, 0, 0, 0, 0, 9, 1, 0);
    ori5   = mk(1, 2, 0, 0, 0, 5, 1, 0);
    beq_e  = mk(0, 3, 0, 0, 0, 0, 0, 0);
    mult_e = mk(0, 0, 1, 0, 0, 0, 0, 0);
    mflo3  = mk(0, 0, 0, 0, 0, 3, 1, 3);

    // load-use through rs/rt, then through sw's rt
    cur = "loaduse";
    step(i_ins(6'h23, 0, 8, 0), 0, 0, lw8);
    chk("ExtOp_lw", ExtOp_D, 1);
    step(r_ins(8, 8, 9, 6'h21), 1, 0, '0);
    step(r_ins(8, 8, 9, 6'h21), 0, 0, addu9);
    flush();
    step(i_ins(6'h23, 0, 8, 0), 0, 0, lw8);
    step(i_ins(6'h2b, 9, 8, 0), 1, 0, '0);
    step(i_ins(6'h2b, 9, 8, 0), 0, 0, mk(1, 0, 0, 0, 1, 0, 0, 0));
    flush();

    // branch operand hazards
    cur = "branch";
    step(i_ins(6'h0d, 0, 5, 1), 0, 0, ori5);
    chk("ExtOp_ori", ExtOp_D, 0);
    step(i_ins(6'h04, 5, 5, 0), 1, 0, '0);
    chk("nPC_beq", nPC_sel_D, 1);
    step(i_ins(6'h04, 5, 5, 0), 0, 0, beq_e);
    step(i_ins(6'h0d, 0, 5, 1), 0, 0, ori5);
    step(NOP, 0, 0, '0);
    step(i_ins(6'h04, 5, 5, 0), 0, 0, beq_e);
    step(i_ins(6'h23, 0, 7, 0), 0, 0, mk(1, 0, 0, 0, 0, 7, 1, 1));
    step(NOP, 0, 0, '0);
    step(i_ins(6'h04, 7, 0, 0), 1, 0, '0);
    step(i_ins(6'h04, 7, 0, 0), 0, 0, beq_e);
    step(i_ins(6'h0d, 0, 31, 4), 0, 0, mk(1, 2, 0, 0, 0, 31, 1, 0));
    step(r_ins(31, 0, 0, 6'h08), 1, 0, '0);
    chk("nPC_jr", nPC_sel_D, 3);
    step(r_ins(31, 0, 0, 6'h08), 0, 0, '0);
    step(i_ins(6'h0f, 0, 6, 16'h1234), 0, 0, mk(1, 0, 0, 0, 0, 6, 1, 0));
    chk("ExtOp_lui", ExtOp_D, 2);
    flush();

    // mult then mflo: mflo waits out the start cycle plus 5 busy cycles
    cur = "mult";
    do_reset();
    step(r_ins(1, 2, 0, 6'h18), 0, 0, mult_e);
    step(r_ins(0, 0, 3, 6'h12), 1, 0, '0);
    repeat (5) step(r_ins(0, 0, 3, 6'h12), 1, 1, '0);
    step(r_ins(0, 0, 3, 6'h12), 0, 0, mflo3);
    flush();
    step(r_ins(4, 0, 0, 6'h11), 0, 0, mk(0, 0, 0, 4, 0, 0, 0, 0));
    step(NOP, 0, 0, '0);
    flush();

    // div with DIV_CYCLES=3, reset on the second busy cycle while mflo stalls
    cur = "div";
    do_reset();
    step(r_ins(1, 2, 0, 6'h1a), 0, 0, mk(0, 0, 1, 2, 0, 0, 0, 0));
    step(NOP, 0, 0, '0);
    step(NOP, 0, 1, '0);
    instr_D = r_ins(0, 0, 3, 6'h12);
    @(negedge clk);
    chk("busy2", busy, 1);
    chk("stall_busy2", stall, 1);
    do_reset();
    step(NOP, 0, 0, '0);

    // jal and j
    cur = "jump";
    instr_D = {6'h03, 26'h40};
    #1;
    chk("nPC_jal", nPC_sel_D, 2);
    step({6'h03, 26'h40}, 0, 0, mk(0, 0, 0, 0, 0, 31, 1, 2));
    step({6'h02, 26'h80}, 0, 0, '0);
    chk("nPC_j", nPC_sel_D, 2);
    flush();

    // $0 destination, undecoded encodings
    cur = "zero";
    step(r_ins(1, 2, 0, 6'h21), 0, 0, '0);
    step(r_ins(0, 0, 4, 6'h21), 0, 0, mk(0, 0, 0, 0, 0, 4, 1, 0));
    step(32'hFC00_0000, 0, 0, '0);
    step(r_ins(1, 2, 5, 6'h21) | 32'h0000_0040, 0, 0, '0);
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
